ysyx_22040759_ifu: RTL and testbench

Instruction fetch unit for the single-issue RV64 core. Owns the PC register, issues instruction-memory read requests over a valid/ready request channel, captures the 32-bit response, and holds instruction and PC stable for the decode/control stage until the execute side signals completion. Next PC comes from the `pc_sel`/ALU-result pair produced by the decode/control path and ALU, so jal/jalr redirect the fetch stream.

---
 rtl/ysyx_22040759_ifu_pkg.sv | 28 ++
 rtl/ysyx_22040759_ifu_if.sv | 28 ++
 rtl/ysyx_22040759_pc_next.sv | 17 +
 rtl/ysyx_22040759_ifu.sv | 90 +++++++++
 tb/tb_ysyx_22040759_ifu.sv | 294 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/ysyx_22040759_ifu_pkg.sv
// Shared types and constants for the instruction fetch unit and its decode-side users.
// Holds FSM state encoding, reset defaults and the pc_sel encoding.
package ysyx_22040759_ifu_pkg;

    typedef logic [63:0] addr_t;
    typedef logic [31:0] inst_t;

    typedef enum logic [2:0] {
        StBoot,
        StReq,
        StWait,
        StValid,
        StErr
    } ifu_state_e;

    typedef enum logic {
        PcPc  = 1'b0,
        PcAlu = 1'b1
    } pc_sel_e;

    localparam addr_t DefaultResetPc = 64'h0000_0000_8000_0000;
    localparam inst_t DefaultNopInst = 32'h0000_0013;

    function automatic logic is_misaligned(input addr_t addr);
        return (addr & addr_t'(3)) != '0;
    endfunction

endpackage

// File: rtl/ysyx_22040759_ifu_if.sv
// Instruction-memory request/response channel between the fetch unit (master)
// and instruction memory (slave).
interface ysyx_22040759_ifu_if;
    import ysyx_22040759_ifu_pkg::*;

    logic  req_valid;
    addr_t req_addr;
    logic  req_ready;
    logic  rsp_valid;
    inst_t rsp_data;

    modport master (
        output req_valid,
        output req_addr,
        input  req_ready,
        input  rsp_valid,
        input  rsp_data
    );

    modport slave (
        input  req_valid,
        input  req_addr,
        output req_ready,
        output rsp_valid,
        output rsp_data
    );

endinterface

// File: rtl/ysyx_22040759_pc_next.sv
// Combinational next-PC selection: sequential pc+4 or a redirect target,
// plus the alignment fault flag for whichever address is chosen.
module ysyx_22040759_pc_next
    import ysyx_22040759_ifu_pkg::*;
(
    input  addr_t pc_i,
    input  logic  pc_sel_i,
    input  addr_t target_i,
    output addr_t next_pc_o,
    output logic  misalign_o
);

    // Bit 0 of a redirect target is always dropped (jalr); only bit 1 can fault.
    assign next_pc_o  = (pc_sel_i == PcAlu) ? (target_i & ~addr_t'(1)) : pc_i + addr_t'(4);
    assign misalign_o = is_misaligned(next_pc_o);

endmodule

// File: rtl/ysyx_22040759_ifu.sv
// Instruction fetch unit: owns the PC, fetches over a valid/ready request channel and
// holds each fetched instruction for decode until the execute side retires it.
module ysyx_22040759_ifu
    import ysyx_22040759_ifu_pkg::*;
#(
    parameter addr_t RESET_PC = DefaultResetPc,
    parameter inst_t NOP_INST = DefaultNopInst
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       pc_sel,
    input  addr_t                      alu_result,
    input  logic                       ex_done,
    ysyx_22040759_ifu_if.master        imem,
    output inst_t                      inst_o,
    output addr_t                      pc_o,
    output logic                       inst_valid,
    output logic                       misalign_o,
    output logic [63:0]                retire_cnt
);

    ifu_state_e  state_q, state_d;
    addr_t       pc_q, pc_d;
    inst_t       inst_q, inst_d;
    logic [63:0] retire_cnt_q, retire_cnt_d;

    addr_t next_pc;
    logic  next_misalign;

    ysyx_22040759_pc_next u_pc_next (
        .pc_i       (pc_q),
        .pc_sel_i   (pc_sel),
        .target_i   (alu_result),
        .next_pc_o  (next_pc),
        .misalign_o (next_misalign)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= StBoot;
            pc_q         <= RESET_PC;
            inst_q       <= NOP_INST;
            retire_cnt_q <= '0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            inst_q       <= inst_d;
            retire_cnt_q <= retire_cnt_d;
        end
    end

    // Memory inputs are only consumed in the state that expects them; anything else is dropped.
    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        inst_d       = inst_q;
        retire_cnt_d = retire_cnt_q;
        case (state_q)
            StBoot: state_d = StReq;
            StReq: begin
                if (imem.req_ready) state_d = StWait;
            end
            StWait: begin
                if (imem.rsp_valid) begin
                    inst_d  = imem.rsp_data;
                    state_d = StValid;
                end
            end
            StValid: begin
                if (ex_done) begin
                    pc_d         = next_pc;
                    retire_cnt_d = retire_cnt_q + 64'd1;
                    inst_d       = NOP_INST;
                    state_d      = next_misalign ? StErr : StReq;
                end
            end
            StErr:   state_d = StErr;
            default: state_d = StBoot;
        endcase
    end

    assign imem.req_valid = (state_q == StReq);
    assign imem.req_addr  = pc_q;
    assign inst_valid     = (state_q == StValid);
    assign misalign_o     = (state_q == StErr);
    assign inst_o         = inst_q;
    assign pc_o           = pc_q;
    assign retire_cnt     = retire_cnt_q;

endmodule

// File: tb/tb_ysyx_22040759_ifu.sv
// Scoreboard bench for the fetch unit: a randomised memory and execute driver, a
// spec-level PC/retire model feeding an expectation queue, and an independent monitor.
module tb_ysyx_22040759_ifu;

    localparam logic [63:0] RST_PC = 64'h0000_0000_8000_0000;
    localparam logic [31:0] NOP    = 32'h0000_0013;

    typedef struct {
        logic        err;
        logic [63:0] pc;
        logic [31:0] inst;
        logic [63:0] retire;
    } exp_t;

    typedef struct {
        logic        sel;
        logic [63:0] tgt;
    } cmd_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        pc_sel = 1'b0;
    logic [63:0] alu_result = '0;
    logic        ex_done = 1'b0;
    logic [31:0] inst_o;
    logic [63:0] pc_o;
    logic        inst_valid;
    logic        misalign_o;
    logic [63:0] retire_cnt;

    ysyx_22040759_ifu_if imem_bus ();

    ysyx_22040759_ifu dut (
        .clk        (clk),
        .rst        (rst),
        .pc_sel     (pc_sel),
        .alu_result (alu_result),
        .ex_done    (ex_done),
        .imem       (imem_bus),
        .inst_o     (inst_o),
        .pc_o       (pc_o),
        .inst_valid (inst_valid),
        .misalign_o (misalign_o),
        .retire_cnt (retire_cnt)
    );

    int   total = 0;
    int   bad = 0;
    int   pops = 0;
    bit   zero_mode = 1'b1;
    bit   exec_en = 1'b0;
    exp_t expq[$];
    cmd_t dq[$];

    always #5 clk = ~clk;

    // Instruction memory contents as a pure function of the address.
    function automatic logic [31:0] mem_word(input logic [63:0] a);
        if (a == RST_PC) return 32'h0010_0093;
        return a[63:32] ^ {a[29:0], 2'b11} ^ 32'h1357_9BDF;
    endfunction

    function automatic logic [63:0] rand_target();
        int          r;
        logic [63:0] t;
        r = $urandom_range(0, 19);
        if (r == 0)      t = 64'hFFFF_FFFF_FFFF_FFFC | 64'($urandom_range(0, 1));
        else if (r == 1) t = {$urandom, $urandom};
        else if (r == 2) t = 64'h0000_0000_8000_0103;
        else if (r == 3) t = 64'h0000_0000_8000_0101;
        else t = {32'h0, 32'h8000_0000 | ($urandom & 32'h0000_FFFC)} | 64'($urandom_range(0, 1));
        return t;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
        end
    endtask

    // Memory slave: random ready, 1..4 cycle response latency, stale responses when idle.
    initial begin : mem_model
        bit          pending;
        bit          hs;
        int          cd;
        int          stale;
        logic [63:0] addr_l;
        logic [63:0] paddr;
        pending = 0; hs = 0; cd = 0; stale = 0; addr_l = '0; paddr = '0;
        imem_bus.req_ready = 1'b0;
        imem_bus.rsp_valid = 1'b0;
        imem_bus.rsp_data  = '0;
        forever begin
            @(posedge clk); #3;
            imem_bus.rsp_valid = 1'b0;
            if (rst) begin
                pending = 0; hs = 0; stale = 2;
                imem_bus.req_ready = 1'b0;
                imem_bus.rsp_valid = 1'b1;
                imem_bus.rsp_data  = 32'hDEAD_BEEF;
                continue;
            end
            if (hs) begin
                pending = 1;
                paddr   = addr_l;
                cd      = zero_mode ? 0 : int'($urandom_range(0, 3));
            end
            if (pending) begin
                if (cd == 0) begin
                    imem_bus.rsp_valid = 1'b1;
                    imem_bus.rsp_data  = mem_word(paddr);
                    pending = 0;
                end else begin
                    cd--;
                end
            end else if (stale > 0 || (!zero_mode && $urandom_range(0, 7) == 0)) begin
                imem_bus.rsp_valid = 1'b1;
                imem_bus.rsp_data  = $urandom;
            end
            if (stale > 0) stale--;
            imem_bus.req_ready = zero_mode ? 1'b1 : ($urandom_range(0, 9) < 6);
            hs = imem_bus.req_valid && imem_bus.req_ready;
            if (hs) addr_l = imem_bus.req_addr;
        end
    end

    // Execute driver plus reference model: next PC and retire count from the spec rules.
    initial begin : exec_drv
        logic [63:0] mpc;
        logic [63:0] mret;
        logic [63:0] nxt;
        cmd_t        c;
        bit          fire;
        mpc = RST_PC; mret = '0; nxt = '0; c = '{1'b0, 64'h0};
        forever begin
            @(posedge clk); #2;
            ex_done = 1'b0;
            if (rst) begin
                mpc  = RST_PC;
                mret = '0;
                expq.delete();
                expq.push_back('{1'b0, RST_PC, mem_word(RST_PC), 64'd0});
                continue;
            end
            fire = 0;
            if (dq.size() > 0) begin
                if (inst_valid) begin
                    c    = dq.pop_front();
                    fire = 1;
                end
            end else if (exec_en) begin
                c.sel = 1'($urandom_range(0, 1));
                c.tgt = rand_target();
                fire  = inst_valid ? ($urandom_range(0, 1) == 1) : ($urandom_range(0, 9) == 0);
                pc_sel     = c.sel;
                alu_result = c.tgt;
            end
            if (fire) begin
                ex_done    = 1'b1;
                pc_sel     = c.sel;
                alu_result = c.tgt;
                if (inst_valid) begin
                    nxt  = c.sel ? {c.tgt[63:1], 1'b0} : mpc + 64'd4;
                    mpc  = nxt;
                    mret = mret + 64'd1;
                    if (nxt[1:0] != 2'b00) expq.push_back('{1'b1, nxt, NOP, mret});
                    else expq.push_back('{1'b0, nxt, mem_word(nxt), mret});
                end
            end
        end
    end

    // Monitor: pops an expectation whenever the DUT presents an instruction or faults.
    initial begin : monitor
        exp_t        cur;
        bit          piv;
        bit          pmis;
        bit          prv;
        logic [63:0] paddr;
        cur = '{1'b0, RST_PC, NOP, 64'd0};
        piv = 0; pmis = 0; prv = 0; paddr = '0;
        forever begin
            @(posedge clk); #1;
            if (rst) begin
                piv = 0; pmis = 0; prv = 0;
                continue;
            end
            if (prv) begin
                if (imem_bus.req_ready) begin
                    chk("req_drop_after_accept", 64'(imem_bus.req_valid), 64'd0);
                end else begin
                    chk("req_held_valid", 64'(imem_bus.req_valid), 64'd1);
                    chk("req_held_addr", imem_bus.req_addr, paddr);
                end
            end
            if (inst_valid && !piv) begin
                if (expq.size() == 0) begin
                    chk("unexpected_valid_qsize", 64'(expq.size()), 64'd1);
                end else begin
                    cur = expq.pop_front();
                    pops++;
                    chk("fetch_kind", 64'(cur.err), 64'd0);
                    chk("fetch_pc", pc_o, cur.pc);
                    chk("fetch_inst", 64'(inst_o), 64'(cur.inst));
                    chk("fetch_retire", retire_cnt, cur.retire);
                end
            end else if (inst_valid) begin
                chk("hold_pc", pc_o, cur.pc);
                chk("hold_inst", 64'(inst_o), 64'(cur.inst));
            end
            if (!inst_valid) chk("idle_inst_nop", 64'(inst_o), 64'(NOP));
            if (misalign_o && !pmis) begin
                if (expq.size() == 0) begin
                    chk("unexpected_err_qsize", 64'(expq.size()), 64'd1);
                end else begin
                    cur = expq.pop_front();
                    pops++;
                    chk("err_kind", 64'(cur.err), 64'd1);
                    chk("err_target_pc", pc_o, cur.pc);
                    chk("err_retire", retire_cnt, cur.retire);
                end
            end
            if (misalign_o) begin
                chk("err_no_req", 64'(imem_bus.req_valid), 64'd0);
                chk("err_no_valid", 64'(inst_valid), 64'd0);
            end
            piv   = inst_valid;
            pmis  = misalign_o;
            prv   = imem_bus.req_valid;
            paddr = imem_bus.req_addr;
        end
    end

    task automatic reset_pulse();
        rst = 1'b1;
        #1;
        chk("rst_pc", pc_o, RST_PC);
        chk("rst_inst", 64'(inst_o), 64'(NOP));
        chk("rst_inst_valid", 64'(inst_valid), 64'd0);
        chk("rst_req_valid", 64'(imem_bus.req_valid), 64'd0);
        chk("rst_misalign", 64'(misalign_o), 64'd0);
        chk("rst_retire", retire_cnt, 64'd0);
        @(posedge clk); #4;
        rst = 1'b0;
    endtask

    initial begin : main
        int n;
        repeat (2) @(posedge clk);
        #4;
        reset_pulse();
        // Zero-wait memory: BOOT, REQ, WAIT, then the first instruction is presented.
        @(posedge clk); #4;
        chk("first_req_valid", 64'(imem_bus.req_valid), 64'd1);
        chk("first_req_addr", imem_bus.req_addr, RST_PC);
        chk("first_no_valid", 64'(inst_valid), 64'd0);
        @(posedge clk); #4;
        chk("wait_req_low", 64'(imem_bus.req_valid), 64'd0);
        chk("wait_no_valid", 64'(inst_valid), 64'd0);
        @(posedge clk); #4;
        chk("first_valid", 64'(inst_valid), 64'd1);
        chk("first_inst", 64'(inst_o), 64'h0010_0093);
        chk("first_pc", pc_o, RST_PC);
        dq.push_back('{1'b0, 64'h0});
        dq.push_back('{1'b1, 64'h0000_0000_8000_0011});
        dq.push_back('{1'b1, 64'h0000_0000_8000_0101});
        dq.push_back('{1'b1, 64'h0000_0000_8000_0103});
        n = 0;
        while (!misalign_o && n < 100) begin
            @(posedge clk); #4;
            n++;
        end
        chk("zero_wait_cycles_to_err", 64'(n), 64'd11);
        chk("directed_misalign", 64'(misalign_o), 64'd1);
        chk("directed_err_pc", pc_o, 64'h0000_0000_8000_0102);
        chk("directed_err_retire", retire_cnt, 64'd4);

        zero_mode = 1'b0;
        exec_en   = 1'b1;
        reset_pulse();
        for (int cyc = 0; cyc < 6000; cyc++) begin
            @(posedge clk); #4;
            if (misalign_o ? ($urandom_range(0, 3) == 0)
                           : (!imem_bus.req_valid && !inst_valid && $urandom_range(0, 59) == 0))
                reset_pulse();
        end
        chk("progress_pops", 64'(pops > 50), 64'd1);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
